// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a shared 512x16 single-port RAM.
//
// Each transaction takes three cycles:
//   IDLE  - sample requests and latch the winner into grant
//   ISSUE - forward the winner's live cmd/addr/wdata to the RAM
//   DONE  - pulse the winner's ack and, on a read, capture ram_rdata
//
// Ports
//   clk, reset                 rising-edge clock; synchronous active-high reset
//   p0_cmd/addr/wdata (in)     CPU request (cmd 01 read, 10 write, 00/11 none)
//   p0_rdata/p0_ack (out)      CPU read data register and completion pulse
//   p1_*                       the same set for the DMA/IO requester
//   ram_cmd/addr/wdata (out)   command to the RAM; zero outside ISSUE
//   ram_rdata (in)             RAM read data, valid the cycle after a read
//   grant (out)                one-hot owner of the transaction; 00 when idle
//   dbg_state (out)            FSM state: 0 IDLE, 1 ISSUE, 2 DONE
//
// Handshake: a requester raises cmd with addr/wdata and holds all three
// stable until the cycle its ack is high; ack is a single-cycle pulse.
// Nothing is buffered. Dropping cmd before ISSUE aborts the transaction
// without an ack.
//
// Configuration macro MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous
// requests go to the port that did not own the last completed transaction;
// otherwise port0 always wins.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  p0_cmd,
    input  logic [8:0]  p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,
    input  logic [1:0]  p1_cmd,
    input  logic [8:0]  p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,
    output logic [1:0]  ram_cmd,
    output logic [8:0]  ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [1:0]  grant,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_owner_q, last_owner_d;   // 0 = port0, 1 = port1
    logic        read_q, read_d;               // current transaction is a read
    logic [15:0] p0_rdata_q, p1_rdata_q;

    logic        p0_req, p1_req, pick_p1;
    logic [1:0]  sel_cmd;
    logic [8:0]  sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_req;

    assign p0_req = (p0_cmd == 2'b01) || (p0_cmd == 2'b10);
    assign p1_req = (p1_cmd == 2'b01) || (p1_cmd == 2'b10);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie, port1 wins only if port0 owned the last completed transaction.
    assign pick_p1 = p1_req && (!p0_req || !last_owner_q);
`else
    assign pick_p1 = p1_req && !p0_req;
`endif

    // Live inputs of the granted port; grant is one-hot so bit 1 selects.
    assign sel_cmd   = grant_q[1] ? p1_cmd   : p0_cmd;
    assign sel_addr  = grant_q[1] ? p1_addr  : p0_addr;
    assign sel_wdata = grant_q[1] ? p1_wdata : p0_wdata;
    assign sel_req   = (sel_cmd == 2'b01) || (sel_cmd == 2'b10);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        read_d       = read_q;
        ram_cmd      = 2'b00;
        ram_addr     = 9'd0;
        ram_wdata    = 16'd0;
        p0_ack       = 1'b0;
        p1_ack       = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d = pick_p1 ? 2'b10 : 2'b01;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_addr  = sel_addr;
                ram_wdata = sel_wdata;
                if (sel_req) begin
                    ram_cmd = sel_cmd;
                    read_d  = (sel_cmd == 2'b01);
                    state_d = DONE;
                end else begin
                    // Requester withdrew: abort silently.
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            DONE: begin
                p0_ack       = grant_q[0];
                p1_ack       = grant_q[1];
                last_owner_d = grant_q[1];
                grant_d      = 2'b00;
                state_d      = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
        // Reset wins even in the cycle it is asserted: no RAM command and no
        // ack escape from a transaction that is being aborted.
        if (reset) begin
            ram_cmd   = 2'b00;
            ram_addr  = 9'd0;
            ram_wdata = 16'd0;
            p0_ack    = 1'b0;
            p1_ack    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            read_q       <= 1'b0;
            p0_rdata_q   <= 16'd0;
            p1_rdata_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            read_q       <= read_d;
            if (state_q == DONE && read_q) begin
                if (grant_q[0]) p0_rdata_q <= ram_rdata;
                if (grant_q[1]) p1_rdata_q <= ram_rdata;
            end
        end
    end

    assign grant     = reset ? 2'b00 : grant_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model of the arbiter and a reference copy of the RAM contents.
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  p0_cmd = 2'b00, p1_cmd = 2'b00;
    logic [8:0]  p0_addr = 9'd0, p1_addr = 9'd0;
    logic [15:0] p0_wdata = 16'd0, p1_wdata = 16'd0;
    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [1:0]  ram_cmd, grant, dbg_state;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'd0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .ram_cmd(ram_cmd), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .grant(grant), .dbg_state(dbg_state)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- RAM environment ----------------
    logic [15:0] env_mem [512];
    logic [15:0] ref_mem [512];

    always @(posedge clk) begin
        if (ram_cmd == 2'b10) env_mem[ram_addr] <= ram_wdata;
        // Garbage outside the valid cycle exposes a mistimed capture.
        ram_rdata <= (ram_cmd == 2'b01) ? env_mem[ram_addr] : 16'($urandom);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];   // {port, read data} per completed read

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_req(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction
    function automatic logic [1:0] cmd_of(input int p);
        return p == 1 ? p1_cmd : p0_cmd;
    endfunction
    function automatic logic [8:0] addr_of(input int p);
        return p == 1 ? p1_addr : p0_addr;
    endfunction
    function automatic logic [15:0] wdata_of(input int p);
        return p == 1 ? p1_wdata : p0_wdata;
    endfunction

    // ---------------- behavioural model ----------------
    // A transaction is an owner (or -1 when idle) plus "issued yet?".
    int          m_owner = -1;
    bit          m_done  = 1'b0;
    int          m_last  = 1;
    bit          m_rd    = 1'b0;
    logic [15:0] m_rval  = 16'd0;
    logic [15:0] m_rdata [2];
    bit          m_chk_rd = 1'b0;
    bit          started  = 1'b0;

    always @(posedge clk) begin
        m_chk_rd <= 1'b0;
        if (reset) begin
            m_owner    <= -1;
            m_done     <= 1'b0;
            m_last     <= 1;
            m_rdata[0] <= 16'd0;
            m_rdata[1] <= 16'd0;
        end else if (m_owner < 0) begin
            if (is_req(p0_cmd) && is_req(p1_cmd)) m_owner <= RR ? 1 - m_last : 0;
            else if (is_req(p0_cmd))              m_owner <= 0;
            else if (is_req(p1_cmd))              m_owner <= 1;
            m_done <= 1'b0;
        end else if (!m_done) begin
            if (is_req(cmd_of(m_owner))) begin
                m_done <= 1'b1;
                m_rd   <= (cmd_of(m_owner) == 2'b01);
                m_rval <= ref_mem[addr_of(m_owner)];
                if (cmd_of(m_owner) == 2'b10) ref_mem[addr_of(m_owner)] <= wdata_of(m_owner);
            end else begin
                m_owner <= -1;
            end
        end else begin
            if (m_rd) begin
                m_rdata[m_owner] <= m_rval;
                exp_q.push_back({m_owner[0], m_rval});
                m_chk_rd <= 1'b1;
            end
            m_last  <= m_owner;
            m_owner <= -1;
            m_done  <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [1:0]  e_grant, e_cmd, e_state;
    logic [8:0]  e_addr;
    logic [15:0] e_wdata;
    logic [16:0] e_rd;

    always @(negedge clk) begin
        if (started) begin
            e_grant = 2'b00; e_cmd = 2'b00; e_addr = 9'd0; e_wdata = 16'd0;
            e_state = (m_owner < 0) ? 2'd0 : (m_done ? 2'd2 : 2'd1);
            if (!reset && m_owner >= 0) begin
                e_grant = (m_owner == 1) ? 2'b10 : 2'b01;
                if (!m_done) begin
                    e_addr  = addr_of(m_owner);
                    e_wdata = wdata_of(m_owner);
                    e_cmd   = is_req(cmd_of(m_owner)) ? cmd_of(m_owner) : 2'b00;
                end
            end
            chk("grant", 32'(grant), 32'(e_grant));
            chk("ram_cmd", 32'(ram_cmd), 32'(e_cmd));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
            chk("p0_ack", 32'(p0_ack), 32'(!reset && m_owner == 0 && m_done));
            chk("p1_ack", 32'(p1_ack), 32'(!reset && m_owner == 1 && m_done));
            chk("p0_rdata", 32'(p0_rdata), 32'(m_rdata[0]));
            chk("p1_rdata", 32'(p1_rdata), 32'(m_rdata[1]));
            chk("dbg_state", 32'(dbg_state), 32'(e_state));
            if (m_chk_rd) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_nonempty", 32'(0), 32'(1));
                end else begin
                    e_rd = exp_q.pop_front();
                    chk("read_result", 32'(e_rd[16] ? p1_rdata : p0_rdata), 32'(e_rd[15:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit acked, inout logic [1:0] cmd,
                              inout logic [8:0] addr, inout logic [15:0] wdata);
        int r;
        if (acked) begin
            if ($urandom_range(0, 1) == 0) cmd = 2'b00;   // else re-request
        end else if (cmd == 2'b11) begin
            if ($urandom_range(0, 1) == 0) cmd = 2'b00;
        end else if (cmd != 2'b00) begin
            if ($urandom_range(0, 99) < 3) cmd = 2'b00;   // withdraw
        end else if ($urandom_range(0, 99) < 35) begin
            r     = int'($urandom_range(0, 9));
            cmd   = (r == 0) ? 2'b11 : (r < 5 ? 2'b01 : 2'b10);
            addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                                : 9'($urandom_range(0, 15));
            wdata = 16'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    int  acks0, acks1;
    bit  ack0_seen, ack1_seen;

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case (i)
                5:       v = 16'hBEEF;
                3:       v = 16'h1111;
                4:       v = 16'h2222;
                16:      v = 16'hA5A5;
                default: ;
            endcase
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        m_rdata[0] = 16'd0;
        m_rdata[1] = 16'd0;

        repeat (3) tick();
        started = 1'b1;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_ram_cmd", 32'(ram_cmd), 32'(0));
        chk("rst_p0_rdata", 32'(p0_rdata), 32'(0));
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(dbg_state), 32'(0));

        // p0 read of 0x005
        tick(); p0_cmd = 2'b01; p0_addr = 9'h005; @(negedge clk);
        tick(); @(negedge clk);
        chk("rd_ram_cmd", 32'(ram_cmd), 32'(1));
        chk("rd_ram_addr", 32'(ram_addr), 32'(5));
        chk("rd_grant", 32'(grant), 32'(1));
        tick(); @(negedge clk);
        chk("rd_p0_ack", 32'(p0_ack), 32'(1));
        tick(); p0_cmd = 2'b00; @(negedge clk);
        chk("rd_p0_rdata", 32'(p0_rdata), 32'(16'hBEEF));
        chk("rd_grant_clr", 32'(grant), 32'(0));

        // p1 write 0x1234 to 0x1FF
        tick(); p1_cmd = 2'b10; p1_addr = 9'h1FF; p1_wdata = 16'h1234; @(negedge clk);
        tick(); @(negedge clk);
        chk("wr_ram_cmd", 32'(ram_cmd), 32'(2));
        chk("wr_ram_addr", 32'(ram_addr), 32'(9'h1FF));
        chk("wr_ram_wdata", 32'(ram_wdata), 32'(16'h1234));
        tick(); @(negedge clk);
        chk("wr_p1_ack", 32'(p1_ack), 32'(1));
        chk("wr_p0_ack", 32'(p0_ack), 32'(0));
        tick(); p1_cmd = 2'b00; @(negedge clk);
        chk("wr_p0_rdata_held", 32'(p0_rdata), 32'(16'hBEEF));

        // p0 withdraws during ISSUE
        tick(); p0_cmd = 2'b01; p0_addr = 9'h007; @(negedge clk);
        tick(); p0_cmd = 2'b00; @(negedge clk);
        chk("abort_ram_cmd", 32'(ram_cmd), 32'(0));
        tick(); @(negedge clk);
        chk("abort_no_ack", 32'(p0_ack), 32'(0));
        chk("abort_idle", 32'(dbg_state), 32'(0));

        // reset during DONE of a p1 read
        tick(); p1_cmd = 2'b01; p1_addr = 9'h010; @(negedge clk);
        tick(); @(negedge clk);
        tick(); reset = 1'b1; @(negedge clk);
        chk("rstdone_p1_ack", 32'(p1_ack), 32'(0));
        chk("rstdone_grant", 32'(grant), 32'(0));
        tick(); reset = 1'b0; p1_cmd = 2'b00; @(negedge clk);
        chk("rstdone_p1_rdata", 32'(p1_rdata), 32'(0));

        // p0 arrives while p1 is in ISSUE
        tick(); p1_cmd = 2'b01; p1_addr = 9'h003; @(negedge clk);
        tick(); p0_cmd = 2'b01; p0_addr = 9'h004; @(negedge clk);
        chk("late_grant_p1", 32'(grant), 32'(2));
        tick(); @(negedge clk);
        chk("late_p1_ack", 32'(p1_ack), 32'(1));
        chk("late_p0_wait", 32'(p0_ack), 32'(0));
        tick(); p1_cmd = 2'b00; @(negedge clk);
        chk("late_p1_rdata", 32'(p1_rdata), 32'(16'h1111));
        tick(); @(negedge clk);
        chk("late_grant_p0", 32'(grant), 32'(1));
        tick(); @(negedge clk);
        chk("late_p0_ack", 32'(p0_ack), 32'(1));
        tick(); p0_cmd = 2'b00; @(negedge clk);
        chk("late_p0_rdata", 32'(p0_rdata), 32'(16'h2222));

        // both ports hold reads for four transactions
        acks0 = 0; acks1 = 0;
        tick(); p0_cmd = 2'b01; p0_addr = 9'h008; p1_cmd = 2'b01; p1_addr = 9'h009;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acks0 += int'(p0_ack);
            acks1 += int'(p1_ack);
            if (i < 11) tick();
        end
        chk("contend_p0_acks", 32'(acks0), RR ? 32'd2 : 32'd4);
        chk("contend_p1_acks", 32'(acks1), RR ? 32'd2 : 32'd0);
        tick(); p0_cmd = 2'b00; p1_cmd = 2'b00; @(negedge clk);

        // randomized traffic
        ack0_seen = 1'b0; ack1_seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_port(ack0_seen, p0_cmd, p0_addr, p0_wdata);
            drive_port(ack1_seen, p1_cmd, p1_addr, p1_wdata);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            ack0_seen = p0_ack;
            ack1_seen = p1_ack;
        end
        tick(); reset = 1'b0; p0_cmd = 2'b00; p1_cmd = 2'b00;
        repeat (5) tick();
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
